fetch_align_buffer: RTL



---
 rtl/fetch_align_if.sv | 39 +++
 rtl/fetch_align_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_align_if.sv
// =====================================================================
// fetch_align_if : I-cache, redirect and IF/ID issue signals of the fetch buffer
// Revision: 1.0
// =====================================================================
`default_nettype none

interface fetch_align_if;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  modport master (
    output icache_ren, icache_addr,
    input  icache_stall, icache_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr, instr_pc, instr_compressed
  );

  modport slave (
    input  icache_ren, icache_addr,
    output icache_stall, icache_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr, instr_pc, instr_compressed
  );
endinterface

`default_nettype wire

// File: rtl/fetch_align_buffer.sv
// =====================================================================
// fetch_align_buffer : halfword queue that aligns RV32IC instructions from
// 32-bit I-cache words. Macro FETCH_ALIGN_PERF_EN adds perf counters.
// Revision: 1.0
// =====================================================================
`default_nettype none

module fetch_align_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fetch_align_if.master            bus,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FETCH_ALIGN_PERF_EN
  ,
  output logic [31:0]              perf_starve_o,
  output logic [31:0]              perf_redirect_o
`endif
);

  localparam int unsigned      PTR_W     = $clog2(DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

  // DEPTH need not be a power of two, so pointer wrap is explicit.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  logic [15:0]      buf_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_nxt, wr_nxt;
  logic [CNT_W-1:0] count_q, count_d, free_slots, push_n, pop_n;
  logic [29:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      issue_pc_q, issue_pc_d;
  logic             skip_low_q, skip_low_d;
  logic [31:0]      instr_q, instr_pc_q;
  logic [15:0]      hw0, hw1, lo_hw, hi_hw;
  logic [31:0]      head_instr;
  logic             head_is32, head_valid;
  logic             fetch_req, fetch_fire, pop;

  always_comb begin
    rd_nxt     = ptr_add(rd_ptr_q, 2'd1);
    wr_nxt     = ptr_add(wr_ptr_q, 2'd1);
    hw0        = buf_q[rd_ptr_q];
    hw1        = buf_q[rd_nxt];
    head_is32  = (hw0[1:0] == 2'b11);
    head_instr = head_is32 ? {hw1, hw0} : {16'h0000, hw0};
    head_valid = rst_n && (head_is32 ? (count_q >= CNT_TWO) : (count_q >= CNT_ONE));
    free_slots = CNT_DEPTH - count_q;
    fetch_req  = rst_n && !bus.redirect_valid &&
                 ((free_slots >= CNT_TWO) || (skip_low_q && (free_slots >= CNT_ONE)));
    fetch_fire = fetch_req && !bus.icache_stall;
    pop        = head_valid && bus.instr_ready && !bus.redirect_valid;
    // Cache returns bytes big-endian; swap so low halfword sits at the word address.
    lo_hw      = {bus.icache_rdata[23:16], bus.icache_rdata[31:24]};
    hi_hw      = {bus.icache_rdata[7:0],   bus.icache_rdata[15:8]};
    push_n     = !fetch_fire ? '0 : (skip_low_q ? CNT_ONE : CNT_TWO);
    pop_n      = !pop        ? '0 : (head_is32  ? CNT_TWO : CNT_ONE);
  end

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    skip_low_d = skip_low_q;
    if (bus.redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = bus.redirect_pc[31:2];
      issue_pc_d = bus.redirect_pc & 32'hFFFF_FFFE;
      skip_low_d = bus.redirect_pc[1];
    end else begin
      count_d = count_q + push_n - pop_n;
      if (fetch_fire) begin
        fetch_pc_d = fetch_pc_q + 30'd1;
        skip_low_d = 1'b0;
        wr_ptr_d   = skip_low_q ? wr_nxt : ptr_add(wr_ptr_q, 2'd2);
      end
      if (pop) begin
        rd_ptr_d   = ptr_add(rd_ptr_q, head_is32 ? 2'd2 : 2'd1);
        issue_pc_d = issue_pc_q + (head_is32 ? 32'd4 : 32'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC[31:2];
      issue_pc_q <= RESET_PC;
      skip_low_q <= RESET_PC[1];
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      skip_low_q <= skip_low_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (fetch_fire) begin
      if (skip_low_q) begin
        buf_q[wr_ptr_q] <= hi_hw;
      end else begin
        buf_q[wr_ptr_q] <= lo_hw;
        buf_q[wr_nxt]   <= hi_hw;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q    <= 32'h0000_0000;
      instr_pc_q <= RESET_PC;
    end else if (head_valid) begin
      instr_q    <= head_instr;
      instr_pc_q <= issue_pc_q;
    end
  end

  assign bus.icache_ren       = fetch_req;
  assign bus.icache_addr      = fetch_pc_q;
  assign bus.instr_valid      = head_valid;
  assign bus.instr            = head_valid ? head_instr : instr_q;
  assign bus.instr_pc         = head_valid ? issue_pc_q : instr_pc_q;
  assign bus.instr_compressed = (bus.instr[1:0] != 2'b11);
  assign count_o              = count_q;

`ifdef FETCH_ALIGN_PERF_EN
  logic [31:0] perf_starve_q, perf_redirect_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_starve_q   <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (bus.instr_ready && !head_valid) perf_starve_q <= perf_starve_q + 32'd1;
      if (bus.redirect_valid)             perf_redirect_q <= perf_redirect_q + 32'd1;
    end
  end

  assign perf_starve_o   = perf_starve_q;
  assign perf_redirect_o = perf_redirect_q;
`endif

endmodule

`default_nettype wire
